// File: rtl/instr_packer_if.sv
// Command input and merged-word AXI-Stream output of instr_packer.
// slave = packer side, master = command generator / downstream side.
interface instr_packer_if #(
    parameter int BG_WIDTH   = 2,
    parameter int BANK_WIDTH = 2,
    parameter int ROW_WIDTH  = 17
);
    logic [2:0]            s_cmd_type;
    logic [BANK_WIDTH-1:0] s_cmd_bank;
    logic [BG_WIDTH-1:0]   s_cmd_bg;
    logic [ROW_WIDTH-1:0]  s_cmd_addr;
    logic                  s_cmd_pall;
    logic [511:0]          s_cmd_wdata;
    logic                  s_cmd_valid;
    logic                  s_cmd_ready;
    logic                  flush;
    logic [639:0]          M_AXIS_TDATA;
    logic                  M_AXIS_TVALID;
    logic                  M_AXIS_TREADY;

    modport slave (
        input  s_cmd_type, s_cmd_bank, s_cmd_bg, s_cmd_addr, s_cmd_pall,
        input  s_cmd_wdata, s_cmd_valid, flush, M_AXIS_TREADY,
        output s_cmd_ready, M_AXIS_TDATA, M_AXIS_TVALID
    );

    modport master (
        output s_cmd_type, s_cmd_bank, s_cmd_bg, s_cmd_addr, s_cmd_pall,
        output s_cmd_wdata, s_cmd_valid, flush, M_AXIS_TREADY,
        input  s_cmd_ready, M_AXIS_TDATA, M_AXIS_TVALID
    );
endinterface

// File: rtl/instr_packer.sv
// Packs DDR4 commands into 640-bit words (4 x 32-bit slots + 512-bit wdata).
// Optional statistics outputs are enabled by defining INSTR_PACKER_STATS_EN.
module instr_packer #(
    parameter int BG_WIDTH      = 2,
    parameter int BANK_WIDTH    = 2,
    parameter int ROW_WIDTH     = 17,
    parameter int FLUSH_TIMEOUT = 16
`ifdef INSTR_PACKER_STATS_EN
    ,
    parameter int CNT_WIDTH     = 16
`endif
) (
    input logic           clk,
    input logic           rst,
    instr_packer_if.slave bus
`ifdef INSTR_PACKER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] stat_words,
    output logic [CNT_WIDTH-1:0] stat_pad_slots
`endif
);

    localparam logic [2:0] TYPE_PRE = 3'd1;
    localparam logic [2:0] TYPE_WR  = 3'd4;
    localparam logic [2:0] TYPE_ILL = 3'd7;
    localparam int IW = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'((FLUSH_TIMEOUT > 0) ? FLUSH_TIMEOUT - 1 : 0);

    logic [BANK_WIDTH-1:0] cmd_bank;
    logic [BG_WIDTH-1:0]   cmd_bg;
    logic [ROW_WIDTH-1:0]  cmd_addr;

    logic [3:0][31:0] slots, slots_n;
    logic [511:0]     wdata, wdata_n;
    logic [2:0]       slot_cnt, cnt_n;
    logic             wr_used, wr_used_n;
    logic             close_pend;
    logic [IW-1:0]    idle_cnt;
    logic             out_full;
    logic [639:0]     out_data;

    logic [31:0] enc;
    logic        is_wr, conflict, ready, accept;
    logic        timeout_hit, close_req, close_any, do_xfer;

    assign cmd_bank = bus.s_cmd_bank;
    assign cmd_bg   = bus.s_cmd_bg;
    assign cmd_addr = bus.s_cmd_addr;

    always_comb begin
        enc = 32'(bus.s_cmd_type) | (32'(cmd_bank) << 3) | (32'(cmd_bg) << 5)
            | (32'(cmd_addr) << 7);
        if (bus.s_cmd_type == TYPE_PRE) enc[7] = cmd_addr[0] | bus.s_cmd_pall;
        if (bus.s_cmd_type == TYPE_ILL) enc = '0;
    end

    assign is_wr    = (bus.s_cmd_type == TYPE_WR);
    assign conflict = bus.s_cmd_valid & is_wr & wr_used;
    assign ready    = !rst && (slot_cnt < 3'd4) && !close_pend && !conflict;
    assign accept   = bus.s_cmd_valid & ready;

    // Assembly contents including this cycle's accept; a closing word always
    // absorbs the command accepted alongside the close.
    always_comb begin
        slots_n   = slots;
        wdata_n   = wdata;
        wr_used_n = wr_used;
        cnt_n     = slot_cnt;
        if (accept) begin
            slots_n[slot_cnt[1:0]] = enc;
            cnt_n = slot_cnt + 3'd1;
            if (is_wr) begin
                wdata_n   = bus.s_cmd_wdata;
                wr_used_n = 1'b1;
            end
        end
    end

    // Timeout fires on the cycle the idle count would reach FLUSH_TIMEOUT.
    assign timeout_hit = (FLUSH_TIMEOUT != 0) && (slot_cnt != 3'd0) && !accept
                         && (idle_cnt == IDLE_LAST);
    assign close_req   = (accept && slot_cnt == 3'd3) || conflict
                         || ((bus.flush || timeout_hit) && cnt_n != 3'd0);
    assign close_any   = close_req | close_pend;
    assign do_xfer     = close_any & (!out_full | bus.M_AXIS_TREADY);

    always_ff @(posedge clk) begin
        if (rst) begin
            slots      <= '0;
            wdata      <= '0;
            wr_used    <= 1'b0;
            slot_cnt   <= 3'd0;
            close_pend <= 1'b0;
            idle_cnt   <= '0;
            out_full   <= 1'b0;
            out_data   <= '0;
        end else if (do_xfer) begin
            out_data   <= {wdata_n, slots_n};
            out_full   <= 1'b1;
            slots      <= '0;
            wdata      <= '0;
            wr_used    <= 1'b0;
            slot_cnt   <= 3'd0;
            close_pend <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            if (bus.M_AXIS_TREADY) out_full <= 1'b0;
            slots      <= slots_n;
            wdata      <= wdata_n;
            wr_used    <= wr_used_n;
            slot_cnt   <= cnt_n;
            close_pend <= close_any;
            if (accept)
                idle_cnt <= '0;
            else if (FLUSH_TIMEOUT != 0 && slot_cnt != 3'd0 && !close_any)
                idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign bus.s_cmd_ready   = ready;
    assign bus.M_AXIS_TVALID = out_full;
    assign bus.M_AXIS_TDATA  = out_data;

`ifdef INSTR_PACKER_STATS_EN
    logic [2:0]         pad_cnt;
    logic [CNT_WIDTH:0] pad_sum;

    assign pad_cnt = 3'd4 - cnt_n;
    assign pad_sum = {1'b0, stat_pad_slots} + (CNT_WIDTH+1)'(pad_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_words     <= '0;
            stat_pad_slots <= '0;
        end else begin
            if (out_full && bus.M_AXIS_TREADY && stat_words != '1)
                stat_words <= stat_words + 1'b1;
            if (do_xfer)
                stat_pad_slots <= pad_sum[CNT_WIDTH] ? '1 : pad_sum[CNT_WIDTH-1:0];
        end
    end
`endif

endmodule
